// File: rtl/user_proj_wbmem.sv
// Wishbone-slave SRAM in a 1 MiB window with programmable read/write wait states and LA status.
// Optional single-entry read buffer enabled by `define WBMEM_RDBUF_EN.
module user_proj_wbmem #(
  parameter logic [11:0] BASE_ADDR    = 12'h380,
  parameter int          DEPTH_LOG2   = 10,
  parameter int          RD_DELAYS    = 10,
  parameter int          WR_DELAYS    = 10,
  parameter int          MPRJ_IO_PADS = 38
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [127:0]            la_data_in,
  output logic [127:0]            la_data_out,
  input  logic [127:0]            la_oenb,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]              irq
);

  localparam logic [15:0] RD_D = 16'(RD_DELAYS);
  localparam logic [15:0] WR_D = 16'(WR_DELAYS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2, S_ACK = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [15:0]             cnt;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [31:0]             dat_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             rd_cnt, wr_cnt;
  logic                    busy;
  logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0]             mem_q;

  logic                    valid;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [15:0]             load_d;
  logic                    rd_hit;

  assign valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE_ADDR);
  assign req_idx = wbs_adr_i[DEPTH_LOG2+1:2];
  assign load_d  = wbs_we_i ? WR_D : RD_D;

`ifdef WBMEM_RDBUF_EN
  // The buffered data is mem_q itself: only reads load it, and writes to the
  // buffered index drop the valid bit, so mem_q always matches a valid entry.
  logic                  buf_vld;
  logic [DEPTH_LOG2-1:0] buf_idx;
  assign rd_hit = buf_vld & ~wbs_we_i & (buf_idx == req_idx);
`else
  assign rd_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (rd_hit)              state_nxt = S_ACK;
          else if (load_d != 16'd0) state_nxt = S_WAIT;
          else                     state_nxt = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i)          state_nxt = S_IDLE;
        else if (cnt <= 16'd1)   state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_ACK;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    wbs_ack_o = (state == S_ACK);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt    <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      idx_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
`ifdef WBMEM_RDBUF_EN
      buf_vld <= 1'b0;
      buf_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (valid) begin
          we_q  <= wbs_we_i;
          sel_q <= wbs_sel_i;
          dat_q <= wbs_dat_i;
          idx_q <= req_idx;
          cnt   <= rd_hit ? 16'd0 : load_d;
        end
        S_WAIT: cnt <= wbs_cyc_i ? cnt - 16'd1 : 16'd0;
        S_ACCESS: begin
          cnt <= '0;
`ifdef WBMEM_RDBUF_EN
          if (!we_q) begin
            buf_vld <= 1'b1;
            buf_idx <= idx_q;
          end else if (idx_q == buf_idx) begin
            buf_vld <= 1'b0;
          end
`endif
        end
        default: begin
          if (we_q) wr_cnt <= wr_cnt + 32'd1;
          else      rd_cnt <= rd_cnt + 32'd1;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (state == S_ACCESS) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++)
          if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end else begin
        mem_q <= mem[idx_q];
      end
    end
  end

  assign wbs_dat_o   = (wbs_ack_o && !we_q) ? mem_q : 32'd0;
  assign la_data_out = {61'd0, state, busy, wr_cnt, rd_cnt};
  assign io_out      = '0;
  assign io_oeb      = '1;
  assign irq         = 3'd0;

  logic unused_ok;
  assign unused_ok = ^{la_data_in, la_oenb, io_in, wbs_adr_i[19:0]};

endmodule

// File: doc/user_proj_wbmem.md
# user_proj_wbmem

Parametrised Wishbone-slave SRAM block for the Caravel user area. It is the next generation of the fixed-latency exmem/BRAM wrapper and decodes a 1 MiB window on the management Wishbone bus. It provides:
- separate programmable read and write wait-state counts;
- abort on master withdrawal;
- an optional single-entry read buffer for zero-wait read hits;
- transaction counters on the logic-analyzer bus.

## Interface
- BASE_ADDR, 12'h380: match value for wbs_adr_i[31:20].
- DEPTH_LOG2, 10: memory depth is 2^DEPTH_LOG2 32-bit words.
- RD_DELAYS, 10: wait cycles inserted before a memory read (0–65535).
- WR_DELAYS, 10: wait cycles inserted before a memory write (0–65535).
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte-lane select; bit n enables byte lane [8n+7:8n].
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address; word index = adr[DEPTH_LOG2+1:2]; adr[1:0] ignored.
- wbs_ack_o  out  1  registered one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o=1, 0 otherwise.
- la_data_in, la_oenb  in  128 each  unused.
- la_data_out  out  128  status bus, bit fields as follows:
  - [31:0]: rd_cnt.
  - [63:32]: wr_cnt.
  - [64]: busy.
  - [66:65]: FSM state.
  - [127:67]: 0.
- io_in  in  MPRJ_IO_PADS  unused.
- io_out  out  MPRJ_IO_PADS  constant 0.
- io_oeb  out  MPRJ_IO_PADS  constant all-ones.
- irq  out  3  constant 0.

## Operation
- valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20]==BASE_ADDR).
- Storage: internal array of 2^DEPTH_LOG2 × 32 with per-byte write enables and synchronous read. Word indices wrap (alias) within the window.
- FSM states: IDLE=0, WAIT=1, ACCESS=2, ACK=3.
- IDLE on valid:
  - Latch we, sel, dat and index.
  - Load a 16-bit down-counter with D (RD_DELAYS or WR_DELAYS).
  - Go to WAIT if D>0, else ACCESS.
- WAIT:
  - Decrement the counter; when it reaches 0, go to ACCESS.
  - If wbs_cyc_i=0, go to IDLE; no memory access, no ack, no counter update.
- ACCESS:
  - Write: only latched sel lanes are updated.
  - Read: the word is captured into the output register.
  - Always go to ACK.
- ACK: wbs_ack_o=1 for exactly this cycle; rd_cnt or wr_cnt increments by 1, wrapping at 2^32. Then go to IDLE.
- The write with sel=4'b0000 path completes the full handshake and is counted, but the memory is unchanged.
- busy=1 in any state except IDLE.
- Requests arriving while busy are not sampled until the FSM returns to IDLE.

## Timing
- Latency: request first sampled valid in cycle t gives wbs_ack_o high in cycle t+D+2.
- With D=0, ack appears in cycle t+2.
- Back-to-back: the earliest next request is sampled in the cycle after ack (t+D+3).
- Reset (async, any state): FSM to IDLE and counter to 0. Outputs and state then hold:
  - wbs_ack_o=0, wbs_dat_o=0, rd_cnt=wr_cnt=0.
  - Read buffer invalidated.
  - Memory contents undefined and not cleared.
- Reset mid-transaction: no ack is issued. A write still in WAIT does not occur. A write in ACCESS may or may not have landed.

## Configuration
- WBMEM_RDBUF_EN defined:
  - A single-entry buffer holds {valid, index, data} of the last completed read.
  - A read in IDLE whose index matches a valid entry goes directly to ACK with the buffered data, giving ack at t+1; it is counted in rd_cnt.
  - Any write that reaches ACCESS to the same index invalidates the entry.
  - Missed reads refill the entry in ACCESS.
- Not defined: no buffer logic; every read takes RD_DELAYS+2 cycles.

## Test plan
- Reset, then RD_DELAYS=10, WR_DELAYS=3: write 0xDEADBEEF to 0x3800_0010 → ack 5 cycles after sample. Read back → ack at +12, data 0xDEADBEEF, rd_cnt=1, wr_cnt=1.
- Byte lanes: write 0x11223344 sel=4'b0101 over 0xFFFFFFFF → readback 0xFF22FF44.
- Abort: drop cyc during WAIT of a write of 0x0 to a cell holding 0xA5A5A5A5 → no ack, wr_cnt unchanged, readback 0xA5A5A5A5.
- Address decode and aliasing:
  - Access at 0x3000_0000 → no ack, state stays IDLE.
  - With DEPTH_LOG2=10, write at 0x3800_1000 → readable at 0x3800_0000.
- With WBMEM_RDBUF_EN: two reads of the same address → acks at t+12 then t+1. A write to that address, then a read → t+12 with the new data. Without the macro → both reads at t+12.
- Assert async reset in ACK cycle → ack drops immediately, counters read 0 on la_data_out.
